// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shifter, at most STEP bit positions per cycle.
// Optional macro SHIFT_ROTATE_EN makes op 2'b10 a rotate-right instead of SLL.
module iter_shift_unit #(
  parameter int STEP = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ShiftStartE,
  input  logic [1:0]  ShiftOpE,
  input  logic [4:0]  ShiftsE,
  input  logic [31:0] ShiftDataE,
  input  logic        FlushE,
  output logic        ShiftBusyE,
  output logic        ShiftDoneM,
  output logic [31:0] ShiftResultM
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  localparam logic [5:0] STEP_W = 6'(STEP);
  logic [1:0]  state, op;
  logic [31:0] data, shifted;
  logic [4:0]  remaining, remNext;
  logic [5:0]  k;
  logic        accept;
  always_comb begin
    k = ({1'b0, remaining} > STEP_W) ? STEP_W : {1'b0, remaining};
    remNext = remaining - k[4:0];
    accept = ShiftStartE && state != SHIFT;
    // SRA re-reads bit 31 of the current data each step, so partial steps compose
    shifted = op == 2'b01 ? data >> k
            : op == 2'b11 ? $unsigned($signed(data) >>> k)
`ifdef SHIFT_ROTATE_EN
            : op == 2'b10 ? (data >> k) | (data << (6'd32 - k))
`endif
            : data << k;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op <= 2'b0;
      data <= 32'h0;
      remaining <= 5'h0;
      ShiftResultM <= 32'h0;
    end else if (FlushE) begin
      state <= IDLE;
    end else if (accept) begin
      data <= ShiftDataE;
      op <= ShiftOpE;
      remaining <= ShiftsE;
      state <= SHIFT;
    end else if (state == SHIFT) begin
      data <= shifted;
      remaining <= remNext;
      if (remNext == 5'h0) begin
        ShiftResultM <= shifted;
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
  assign ShiftBusyE = state == SHIFT;
  assign ShiftDoneM = state == DONE;
endmodule

// File: doc/iter_shift_unit.md
# iter_shift_unit

Multi-cycle shift execution unit in the execute stage of the MIPS core. It consumes the 5-bit shift amount `ShiftsE` produced by the shift-source select, along with the operand and shift opcode. It shifts at most `STEP` bit positions per cycle and returns the result with a one-cycle done pulse toward the memory stage. The pipeline stalls on `ShiftBusyE` while an operation is in flight.

## Interface
- `STEP`, default 8: maximum shift distance applied per cycle. Legal values are 1, 2, 4, 8, 16, 32.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; forces the unit to IDLE immediately.
- `ShiftStartE`  in  1: request a shift; sampled at the rising edge.
- `ShiftOpE`  in  2: 00 SLL, 01 SRL, 11 SRA, 10 ROTR / SLL (see Configuration).
- `ShiftsE`  in  5: shift amount, 0..31.
- `ShiftDataE`  in  32: operand to shift.
- `FlushE`  in  1: pipeline flush; aborts any operation.
- `ShiftBusyE`  out  1: high while in SHIFT; the stall source for the hazard unit.
- `ShiftDoneM`  out  1: one-cycle pulse; `ShiftResultM` is valid in this cycle.
- `ShiftResultM`  out  32: result; held stable until the next accepted start.

## Operation
- States: IDLE, SHIFT, DONE.
- Internal registers: 32-bit data, 2-bit op, 5-bit remaining count.
- IDLE or DONE, with `ShiftStartE`=1 and `FlushE`=0:
  - latch `ShiftDataE`, `ShiftOpE`, `ShiftsE` into data/op/remaining;
  - go to SHIFT.
- IDLE, no start: stay in IDLE.
- DONE, no start: go to IDLE.
- SHIFT, each cycle:
  - k = min(remaining, STEP); shift data by k according to op; remaining -= k.
  - If the new remaining is 0, copy the shifted data to `ShiftResultM` and go to DONE; otherwise stay in SHIFT.
  - Shift amount 0 still spends exactly one SHIFT cycle with k=0.
- Shift rules:
  - SLL fills with 0 from the LSB side.
  - SRL fills with 0 from the MSB side.
  - SRA replicates bit 31 of the current data on every step.
  - Partial steps compose exactly: the final result equals a single shift by the original amount.
- `ShiftStartE` while in SHIFT is ignored (not queued). The hazard unit must hold the request until busy drops.
- `FlushE`=1 in any state:
  - go to IDLE at the next edge;
  - no done pulse; `ShiftResultM` keeps its previous value.
- `FlushE` and `ShiftStartE` in the same cycle: flush wins and the start is dropped.
- Reset (asynchronous assert, any state): state IDLE, `ShiftBusyE`=0, `ShiftDoneM`=0, `ShiftResultM`=32'h0, internal registers 0.
- Reset during SHIFT discards the operation.

## Timing
- Start sampled at edge 0.
- SHIFT occupies cycles 1..n, where n = max(1, ceil(ShiftsE/STEP)).
- DONE is cycle n+1: `ShiftDoneM`=1 and the result is valid.
- `ShiftBusyE` = (state==SHIFT), registered-state decode with no combinational path from inputs.
- `ShiftDoneM` = (state==DONE).
- Back-to-back operation: a start accepted in the DONE cycle enters SHIFT at the next edge, with no IDLE bubble.
- Example latencies with STEP=8, done cycle after start:
  - shamt 0 → 2;
  - shamt 8 → 2;
  - shamt 9 → 3;
  - shamt 31 → 5.
- STEP=32 gives a fixed 2-cycle latency.

## Configuration
- Macro `SHIFT_ROTATE_EN`:
  - Defined: op 10 is ROTR (MIPS32r2 rotate right). Bits shifted out of the LSB re-enter at the MSB on every step, and the result equals a rotate by the full amount.
  - Undefined: op 10 decodes as SLL, and no rotate logic is built.
- Timing and handshake are identical in both builds.

## Test plan
- Reset, then release; start with SLL, data 32'h0000_0001, shamt 31, STEP=8 → busy in cycles 1–4, done pulse in cycle 5, result 32'h8000_0000.
- SRA, data 32'h8000_00F0, shamt 4 → done in cycle 2, result 32'hF800_000F; SRL on the same data → 32'h0800_000F.
- Start with shamt 0, data 32'hDEAD_BEEF, op SRL → one SHIFT cycle, done in cycle 2, result 32'hDEAD_BEEF.
- Start SLL shamt 20, then assert `FlushE` in cycle 2 → IDLE in cycle 3, no done pulse, result keeps its prior value; also start+flush in the same cycle → start dropped, busy never asserts.
- Back-to-back: start in the DONE cycle of the previous operation → busy the next cycle with no IDLE gap; second result correct; a start pulsed mid-SHIFT is ignored.
- With `SHIFT_ROTATE_EN` defined: op 10, data 32'h0000_00F1, shamt 4 → 32'h1000_000F. Without it: the same stimulus gives 32'h0000_0F10.
